// File: rtl/convcor_pkg.sv
// convcor_pkg: shared types and constants for the convcor_n engine.
//   state_t   : controller states (IDLE / LOAD / OUT)
//   MODE_*    : in_mode encodings (0 = convolution, 1 = correlation)
//   aw_of()   : full-precision output component width for a given DW/N
//   cplx_t    : packed complex input sample at the default DW
//   result_t  : packed complex result at the default DW/N
package convcor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic MODE_CONV = 1'b0;
  localparam logic MODE_CORR = 1'b1;

  // Each product needs 2*DW+1 bits (the -128*-128 corner), and summing up
  // to N of them adds $clog2(N) more; one further guard bit keeps it safe.
  function automatic int aw_of(input int dw, input int n);
    return 2 * dw + 2 + $clog2(n);
  endfunction

  localparam int DW_DEF = 8;
  localparam int N_DEF  = 3;
  localparam int AW_DEF = aw_of(DW_DEF, N_DEF);

  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [AW_DEF-1:0] re;
    logic signed [AW_DEF-1:0] im;
  } result_t;

endpackage

// File: rtl/convcor_cmul.sv
// convcor_cmul: combinational signed complex multiply, a * b or a * conj(b).
//   a, b   : packed complex operands {re, im}, DW bits per component
//   conj_b : 1 = use conj(b) (negates the imaginary part of b)
//   p_re   : real part of the product, sign-extended to AW bits
//   p_im   : imaginary part of the product, sign-extended to AW bits
module convcor_cmul #(
  parameter int DW = 8,
  parameter int AW = 20
) (
  input  logic [2*DW-1:0]       a,
  input  logic [2*DW-1:0]       b,
  input  logic                  conj_b,
  output logic signed [AW-1:0]  p_re,
  output logic signed [AW-1:0]  p_im
);

  logic signed [AW-1:0] ar, ai, br, bi, bi_eff;

  // Widen before multiplying so the arithmetic is done at full output width.
  assign ar = {{(AW-DW){a[2*DW-1]}}, a[2*DW-1:DW]};
  assign ai = {{(AW-DW){a[DW-1]}},   a[DW-1:0]};
  assign br = {{(AW-DW){b[2*DW-1]}}, b[2*DW-1:DW]};
  assign bi = {{(AW-DW){b[DW-1]}},   b[DW-1:0]};

  // Conjugating b only flips the sign of its imaginary part.
  assign bi_eff = conj_b ? -bi : bi;

  assign p_re = ar * br - ai * bi_eff;
  assign p_im = ar * bi_eff + ai * br;

endmodule

// File: rtl/convcor_n.sv
// convcor_n: complex convolution / cross-correlation engine.
// Loads two length-N complex sequences over a valid/ready handshake, then
// streams 2N-1 full-precision results with output back-pressure.
// Build option: define CONVCOR_CORR_EN to include correlation mode
// (in_mode honoured); otherwise every burst is a convolution.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input sample handshake
//   in_a, in_b          : operand samples {re, im}, DW bits each
//   in_mode             : 0 conv, 1 corr, sampled with the first sample
//   out_valid/out_ready : result handshake
//   out                 : result {re, im}, AW bits each, 0 when idle
//   out_last            : marks the final result (index 2N-2)
module convcor_n
  import convcor_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [2*DW-1:0]                   in_a,
  input  logic [2*DW-1:0]                   in_b,
  input  logic                              in_mode,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [2*convcor_pkg::aw_of(DW,N)-1:0] out,
  output logic                              out_last
);

  localparam int AW = aw_of(DW, N);
  localparam int IW = $clog2(N);
  localparam int OW = $clog2(2 * N - 1);

  state_t state, next_state;

  logic [2*DW-1:0] a_mem [N];
  logic [2*DW-1:0] b_mem [N];
  logic [2*DW-1:0] a_eff [N];
  logic [2*DW-1:0] b_eff [N];
  logic [2*DW-1:0] tap_a [N];
  logic [2*DW-1:0] tap_b [N];
  logic signed [AW-1:0] p_re [N];
  logic signed [AW-1:0] p_im [N];

  logic [IW-1:0] load_idx;
  logic [OW-1:0] out_idx;
  logic [OW-1:0] calc_m;
  logic signed [AW-1:0] sum_re, sum_im, out_re, out_im;
  logic in_fire, out_fire, last_sample, load_result, corr;

  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign last_sample = (load_idx == IW'(N - 1));
  assign load_result = (in_fire && last_sample) || (out_fire && !out_last);
  assign out         = {out_re, out_im};

`ifdef CONVCOR_CORR_EN
  logic mode_r;

  // The mode is captured with the first sample of a burst and held after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r <= MODE_CONV;
    end else if (state == IDLE && in_fire) begin
      mode_r <= in_mode;
    end
  end

  assign corr = (mode_r == MODE_CORR);
`else
  logic unused_mode;
  assign unused_mode = in_mode;
  assign corr        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_fire) next_state = LOAD;
      LOAD:    if (in_fire && last_sample) next_state = OUT;
      OUT:     if (out_fire && out_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Sample storage, load index and registered in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        a_mem[k] <= '0;
        b_mem[k] <= '0;
      end
      load_idx <= '0;
      in_ready <= 1'b1;
    end else begin
      if (in_fire) begin
        a_mem[load_idx] <= in_a;
        b_mem[load_idx] <= in_b;
        load_idx        <= last_sample ? '0 : load_idx + IW'(1);
      end
      in_ready <= (next_state != OUT);
    end
  end

  // The first result is registered on the same edge that stores the last
  // sample, so the incoming sample is forwarded into the operand view.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      a_eff[k] = a_mem[k];
      b_eff[k] = b_mem[k];
      if (in_fire && (int'(load_idx) == k)) begin
        a_eff[k] = in_a;
        b_eff[k] = in_b;
      end
    end
  end

  // Index of the result being computed: 0 while loading, otherwise the one
  // after the result currently presented.
  assign calc_m = (state == OUT) ? out_idx + OW'(1) : '0;

  // Tap k pairs a[k] with b[m-k] (convolution) or a[k+lag] with b[k]
  // (correlation, lag = m-(N-1)); out-of-range pairs contribute zero.
  always_comb begin
    int m_i, ia, ib;
    m_i = int'(calc_m);
    ia  = 0;
    ib  = 0;
    for (int k = 0; k < N; k++) begin
      if (corr) begin
        ia = k + m_i - (N - 1);
        ib = k;
      end else begin
        ia = k;
        ib = m_i - k;
      end
      tap_a[k] = '0;
      tap_b[k] = '0;
      if (ia >= 0 && ia < N && ib >= 0 && ib < N) begin
        tap_a[k] = a_eff[IW'(ia)];
        tap_b[k] = b_eff[IW'(ib)];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_mul
    convcor_cmul #(.DW(DW), .AW(AW)) u_cmul (
      .a      (tap_a[g]),
      .b      (tap_b[g]),
      .conj_b (corr),
      .p_re   (p_re[g]),
      .p_im   (p_im[g])
    );
  end

  always_comb begin
    sum_re = '0;
    sum_im = '0;
    for (int k = 0; k < N; k++) begin
      sum_re = sum_re + p_re[k];
      sum_im = sum_im + p_im[k];
    end
  end

  // Output register: loads a new result on the last sample or after each
  // accepted non-final result, holds during stalls, clears after the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_last  <= 1'b0;
      out_idx   <= '0;
    end else if (load_result) begin
      out_valid <= 1'b1;
      out_re    <= sum_re;
      out_im    <= sum_im;
      out_last  <= (calc_m == OW'(2 * N - 2));
      out_idx   <= calc_m;
    end else if (out_fire) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_last  <= 1'b0;
      out_idx   <= '0;
    end
  end

endmodule

// File: tb/tb_convcor_n.sv
// tb_convcor_n: scoreboard bench for convcor_n (N=3, DW=8).
// Stimulus pushes hand-computed expected results into a queue; a monitor
// pops and compares on every output handshake. Expectations for in_mode=1
// bursts depend on whether CONVCOR_CORR_EN is defined.
module tb_convcor_n;
  import convcor_pkg::*;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int AW = aw_of(DW, N);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [2*DW-1:0] in_a = '0;
  logic [2*DW-1:0] in_b = '0;
  logic in_mode = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [2*AW-1:0] out;
  logic out_last;

  typedef struct {
    int   re;
    int   im;
    logic last;
  } exp_t;

  exp_t    sb[$];
  int      checks = 0;
  int      errors = 0;
  int      res_count = 0;
  int      exp_re[5];
  int      exp_im[5];
  result_t out_s;

  assign out_s = out;

  convcor_n #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic pushExpected();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      e.re   = exp_re[i];
      e.im   = exp_im[i];
      e.last = (i == 4);
      sb.push_back(e);
    end
  endtask

  // Sends one burst of three samples; later samples carry the inverted
  // mode to show that only the first one matters.
  task automatic applyStimulus(input logic [15:0] a0, a1, a2, b0, b1, b2,
                               input logic mode, input bit gaps);
    logic [15:0] av[3];
    logic [15:0] bv[3];
    int t;
    av[0] = a0; av[1] = a1; av[2] = a2;
    bv[0] = b0; bv[1] = b1; bv[2] = b2;
    for (int i = 0; i < 3; i++) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_a     = av[i];
      in_b     = bv[i];
      in_mode  = (i == 0) ? mode : ~mode;
      t = 0;
      while (!in_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_mode  = 1'b0;
  endtask

  // Returns #1 after the edge of the final handshake of the queued results.
  task automatic waitDrain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_out_zero"}, int'(out != '0), 0);
    checkOutput({tag, "_out_last"}, int'(out_last), 0);
    checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  // Monitor: every accepted result is compared against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput($sformatf("res%0d_re", res_count), int'(out_s.re), e.re);
        checkOutput($sformatf("res%0d_im", res_count), int'(out_s.im), e.im);
        checkOutput($sformatf("res%0d_last", res_count), int'(out_last), int'(e.last));
      end
      res_count++;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    #2;
    checkIdle("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Real convolution
    exp_re = '{1, 3, 6, 5, 3}; exp_im = '{0, 0, 0, 0, 0};
    pushExpected();
    applyStimulus(16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0100, 16'h0100, MODE_CONV, 1'b0);
    waitDrain();
    checkIdle("after_last");

    // Complex convolution, started on the cycle after the last handshake
    exp_re = '{-5, 0, 0, 0, 0}; exp_im = '{10, 0, 0, 0, 0};
    pushExpected();
    applyStimulus(16'h0102, 16'h0000, 16'h0000, 16'h0304, 16'h0000, 16'h0000, MODE_CONV, 1'b0);
    waitDrain();

    // Correlation requests (convolution when the mode is not built)
`ifdef CONVCOR_CORR_EN
    exp_re = '{0, 0, 11, 0, 0}; exp_im = '{0, 0, 2, 0, 0};
`else
    exp_re = '{-5, 0, 0, 0, 0}; exp_im = '{10, 0, 0, 0, 0};
`endif
    pushExpected();
    applyStimulus(16'h0102, 16'h0000, 16'h0000, 16'h0304, 16'h0000, 16'h0000, MODE_CORR, 1'b0);
    waitDrain();

`ifdef CONVCOR_CORR_EN
    exp_re = '{0, 0, 0, 1, 0}; exp_im = '{0, 0, 0, 0, 0};
`else
    exp_re = '{0, 1, 0, 0, 0}; exp_im = '{0, 0, 0, 0, 0};
`endif
    pushExpected();
    applyStimulus(16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0000, MODE_CORR, 1'b0);
    waitDrain();

    // Extremes: (-128-128j)^2 = 32768j per term
    exp_re = '{0, 0, 0, 0, 0}; exp_im = '{32768, 65536, 98304, 65536, 32768};
    pushExpected();
    applyStimulus(16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080, 16'h8080, MODE_CONV, 1'b0);
    waitDrain();

    // Input gaps plus a 3-cycle stall on result 2, with ignored input junk
    exp_re = '{1, 3, 6, 5, 3}; exp_im = '{0, 0, 0, 0, 0};
    pushExpected();
    applyStimulus(16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0100, 16'h0100, MODE_CONV, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 16'h7F7F;
    in_b      = 16'h7F7F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall%0d_valid", i), int'(out_valid), 1);
      checkOutput($sformatf("stall%0d_re", i), int'(out_s.re), 6);
      checkOutput($sformatf("stall%0d_im", i), int'(out_s.im), 0);
      checkOutput($sformatf("stall%0d_last", i), int'(out_last), 0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    waitDrain();

    // Reset during OUT after two results
    exp_re = '{1, 3, 6, 5, 3}; exp_im = '{0, 0, 0, 0, 0};
    pushExpected();
    applyStimulus(16'h0100, 16'h0200, 16'h0300, 16'h0100, 16'h0100, 16'h0100, MODE_CONV, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkIdle("mid_reset");
    checkOutput("mid_reset_consumed", sb.size(), 3);
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Burst after reset
    exp_re = '{-5, 0, 0, 0, 0}; exp_im = '{10, 0, 0, 0, 0};
    pushExpected();
    applyStimulus(16'h0102, 16'h0000, 16'h0000, 16'h0304, 16'h0000, 16'h0000, MODE_CONV, 1'b0);
    waitDrain();
    checkIdle("final");
    checkOutput("results_seen", res_count, 37);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
